// File: rtl/dca_matrix_lsu_inst_arbiter_if.sv
// Requester and LSU instruction-port signals of the matrix LSU instruction arbiter.
// The master side drives requests, LSU accept and LSU finish strobes; the slave side is the arbiter.
interface dca_matrix_lsu_inst_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int BW_INST = 64
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*BW_INST-1:0] req_inst;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         req_read_done;
    logic [NUM_REQ-1:0]         req_write_done;
    logic                       lsu_inst_wvalid;
    logic [BW_INST-1:0]         lsu_inst_wdata;
    logic                       lsu_inst_wready;
    logic                       lsu_read_finish;
    logic                       lsu_write_finish;

    modport master (
        output req_valid, req_inst, lsu_inst_wready, lsu_read_finish, lsu_write_finish,
        input  req_ready, req_read_done, req_write_done, lsu_inst_wvalid, lsu_inst_wdata
    );

    modport slave (
        input  req_valid, req_inst, lsu_inst_wready, lsu_read_finish, lsu_write_finish,
        output req_ready, req_read_done, req_write_done, lsu_inst_wvalid, lsu_inst_wdata
    );
endinterface

// File: rtl/dca_matrix_lsu_inst_arbiter.sv
// Round-robin arbiter sharing the matrix LSU instruction port; per-type in-order tag FIFOs
// route each LSU read/write finish back to the requester that issued the instruction.
module dca_matrix_lsu_inst_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int BW_INST      = 64,
    parameter int BW_OPCODE    = 2,
    parameter int OPCODE_READ  = 0,
    parameter int OPCODE_WRITE = 1,
    parameter int TAG_DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rstnn,
    input  logic                       clear,
    input  logic                       enable,
    dca_matrix_lsu_inst_arbiter_if.slave bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       err_unexpected_finish
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] STATE_IDLE  = 1'b0;
    localparam logic [0:0] STATE_ISSUE = 1'b1;

    logic [0:0]         state_reg;
    logic [GW-1:0]      rr_ptr_reg;
    logic [GW-1:0]      grant_id_reg;
    logic [GW-1:0]      rr_ptr_next;
    logic [NUM_REQ-1:0] read_done_reg;
    logic [NUM_REQ-1:0] write_done_reg;
    logic [NUM_REQ-1:0] read_done_next;
    logic [NUM_REQ-1:0] write_done_next;
    logic               err_reg;

    logic [NUM_REQ-1:0] eligible;
    logic               found;
    logic [GW-1:0]      pick;

    // index 0 tracks reads, index 1 tracks writes
    logic [1:0]         fifo_push;
    logic [1:0]         fifo_pop;
    logic [1:0]         fifo_empty;
    logic [1:0]         fifo_full;
    logic [GW-1:0]      fifo_head [2];

    logic               issue;
    logic               accept;
    logic               finish_err;
    logic [BW_INST-1:0] grant_inst;
    logic [BW_OPCODE-1:0] grant_op;
    logic               op_read;
    logic               op_write;

    assign issue      = (state_reg == STATE_ISSUE);
    assign grant_inst = bus.req_inst[grant_id_reg*BW_INST +: BW_INST];
    assign grant_op   = grant_inst[BW_OPCODE-1:0];
    assign op_read    = (grant_op == BW_OPCODE'(OPCODE_READ));
    assign op_write   = (grant_op == BW_OPCODE'(OPCODE_WRITE));
    assign accept     = issue & enable & bus.lsu_inst_wready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_elig
            logic [BW_OPCODE-1:0] op;
            assign op = bus.req_inst[gi*BW_INST +: BW_OPCODE];
            assign eligible[gi] = bus.req_valid[gi] &
                ((op == BW_OPCODE'(OPCODE_READ))  ? ~fifo_full[0] :
                 (op == BW_OPCODE'(OPCODE_WRITE)) ? ~fifo_full[1] : 1'b1);
        end
    endgenerate

    always_comb begin
        int cand;
        cand  = 0;
        found = 1'b0;
        pick  = rr_ptr_reg;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rr_ptr_reg) + k) % NUM_REQ;
            if (!found && eligible[cand[GW-1:0]]) begin
                found = 1'b1;
                pick  = cand[GW-1:0];
            end
        end
    end

    assign rr_ptr_next = (grant_id_reg == GW'(NUM_REQ - 1)) ? '0 : grant_id_reg + 1'b1;

    assign fifo_push[0] = accept & op_read;
    assign fifo_push[1] = accept & op_write;
    assign fifo_pop[0]  = enable & bus.lsu_read_finish  & ~fifo_empty[0];
    assign fifo_pop[1]  = enable & bus.lsu_write_finish & ~fifo_empty[1];
    assign finish_err   = enable & ((bus.lsu_read_finish  & fifo_empty[0]) |
                                    (bus.lsu_write_finish & fifo_empty[1]));

    generate
        for (gi = 0; gi < 2; gi++) begin : g_tag_fifo
            logic [GW-1:0] mem [TAG_DEPTH];
            logic [PW-1:0] wr_ptr_reg;
            logic [PW-1:0] rd_ptr_reg;
            logic [CW-1:0] count_reg;

            // a pop at full frees the slot the simultaneous push lands in
            always_ff @(posedge clk or negedge rstnn) begin
                if (!rstnn) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else if (clear) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (fifo_push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (fifo_pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    count_reg <= count_reg + CW'(fifo_push[gi]) - CW'(fifo_pop[gi]);
                end
            end

            always_ff @(posedge clk) begin
                if (fifo_push[gi]) mem[wr_ptr_reg] <= grant_id_reg;
            end

            assign fifo_empty[gi] = (count_reg == '0);
            assign fifo_full[gi]  = (count_reg == CW'(TAG_DEPTH));
            assign fifo_head[gi]  = mem[rd_ptr_reg];
        end
    endgenerate

    always_comb begin
        read_done_next  = '0;
        write_done_next = '0;
        if (fifo_pop[0]) read_done_next[fifo_head[0]]  = 1'b1;
        if (fifo_pop[1]) write_done_next[fifo_head[1]] = 1'b1;
        // instructions with no LSU completion report done on the write side right away
        if (accept && !op_read && !op_write) write_done_next[grant_id_reg] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_reg      <= STATE_IDLE;
            rr_ptr_reg     <= '0;
            grant_id_reg   <= '0;
            read_done_reg  <= '0;
            write_done_reg <= '0;
            err_reg        <= 1'b0;
        end else if (clear) begin
            state_reg      <= STATE_IDLE;
            rr_ptr_reg     <= '0;
            grant_id_reg   <= '0;
            read_done_reg  <= '0;
            write_done_reg <= '0;
            err_reg        <= 1'b0;
        end else if (enable) begin
            read_done_reg  <= read_done_next;
            write_done_reg <= write_done_next;
            if (finish_err) err_reg <= 1'b1;
            case (state_reg)
                STATE_IDLE: begin
                    if (found) begin
                        grant_id_reg <= pick;
                        state_reg    <= STATE_ISSUE;
                    end
                end
                default: begin
                    if (accept) begin
                        rr_ptr_reg <= rr_ptr_next;
                        state_reg  <= STATE_IDLE;
                    end
                end
            endcase
        end else begin
            read_done_reg  <= '0;
            write_done_reg <= '0;
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[grant_id_reg] = 1'b1;
    end

    assign bus.lsu_inst_wvalid  = issue & enable;
    assign bus.lsu_inst_wdata   = issue ? grant_inst : '0;
    assign bus.req_read_done    = read_done_reg;
    assign bus.req_write_done   = write_done_reg;
    assign grant_id             = grant_id_reg;
    assign busy                 = issue | ~fifo_empty[0] | ~fifo_empty[1];
    assign err_unexpected_finish = err_reg;
endmodule
